// File: rtl/counter_pkg.sv
// +----------------------------------------------------------------------------+
// | counter_pkg : shared types and helpers for the modulo counter              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package counter_pkg;

    typedef enum logic {
        CNT_DOWN = 1'b0,
        CNT_UP   = 1'b1
    } cnt_dir_e;

    // Never returns 0, so it can size a register even for a range of one value.
    function automatic int unsigned safe_clog2(input longint unsigned value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cnt_prescaler.sv
// +----------------------------------------------------------------------------+
// | cnt_prescaler : enable-gated divider producing one tick per PRESCALE       |
// |                 enabled cycles; collapses to tick = en when PRESCALE = 1   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module cnt_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    generate
        if (PRESCALE == 1) begin : g_bypass
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst_n, clr};
            assign tick     = en;
        end else begin : g_count
            localparam int unsigned     c_PW   = safe_clog2(longint'(PRESCALE));
            localparam logic [c_PW-1:0] c_LAST = c_PW'(PRESCALE - 1);

            logic [c_PW-1:0] r_pre;
            logic            w_tick;

            assign w_tick = en && (r_pre == c_LAST);
            assign tick   = w_tick;

            // A tick always returns pre to 0, even when a load swallows the step.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pre <= '0;
                end else if (clr || w_tick) begin
                    r_pre <= '0;
                end else if (en) begin
                    r_pre <= r_pre + c_PW'(1);
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/mod_counter.sv
// +----------------------------------------------------------------------------+
// | mod_counter : modulo up/down counter with clear, load, enable, prescaler,  |
// |               terminal count, wrap pulse and optional sticky overflow      |
// |               (COUNTER_OVF_STICKY_EN)                                      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mod_counter
    import counter_pkg::*;
#(
    parameter int     WIDTH    = 8,
    parameter longint MOD      = longint'(1) << WIDTH,
    parameter int     PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam int             c_EW  = WIDTH + 1;
    localparam logic [WIDTH:0] c_MAX = c_EW'(MOD - 1);

    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("mod_counter: WIDTH must be in 1..32");
        end
        if (MOD < 2 || MOD > (longint'(1) << WIDTH)) begin : g_bad_mod
            $error("mod_counter: MOD must be in 2..2**WIDTH");
        end
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("mod_counter: PRESCALE must be >= 1");
        end
    endgenerate

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             w_tick;
    logic             w_step;
    logic             w_wrap_step;
    logic             w_at_max;
    logic             w_at_zero;
    logic [WIDTH:0]   w_count_ext;
    logic [WIDTH:0]   w_load_ext;
    logic [WIDTH:0]   w_load_clamped;
    logic [WIDTH:0]   w_step_val;
    cnt_dir_e         w_dir;

    cnt_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (clr),
        .tick  (w_tick)
    );

    // Extended by one bit so MOD = 2**WIDTH compares and clamps without overflow.
    assign w_count_ext    = {1'b0, r_count};
    assign w_load_ext     = {1'b0, load_val};
    assign w_load_clamped = (w_load_ext > c_MAX) ? c_MAX : w_load_ext;
    assign w_dir          = cnt_dir_e'(dir);
    assign w_at_max       = (w_count_ext == c_MAX);
    assign w_at_zero      = (r_count == '0);

    assign w_step      = w_tick && !clr && !load;
    assign w_wrap_step = w_step && ((w_dir == CNT_UP) ? w_at_max : w_at_zero);

    always_comb begin
        w_step_val = w_count_ext;
        if (w_dir == CNT_UP) begin
            w_step_val = w_at_max ? '0 : (w_count_ext + c_EW'(1));
        end else begin
            w_step_val = w_at_zero ? c_MAX : (w_count_ext - c_EW'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= w_wrap_step;
            if (clr) begin
                r_count <= '0;
            end else if (load) begin
                r_count <= WIDTH'(w_load_clamped);
            end else if (w_step) begin
                r_count <= WIDTH'(w_step_val);
            end
        end
    end

`ifdef COUNTER_OVF_STICKY_EN
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (clr) begin
            r_ovf <= 1'b0;
        end else if (w_wrap_step) begin
            r_ovf <= 1'b1;
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign count = r_count;
    assign wrap  = r_wrap;
    assign tc    = (w_dir == CNT_UP) ? w_at_max : w_at_zero;

endmodule

`default_nettype wire

// File: tb/tb_mod_counter.sv
// +----------------------------------------------------------------------------+
// | tb_mod_counter : directed self-checking bench for mod_counter              |
// |                  (MOD=10, PRESCALE=1 and PRESCALE=4 instances)             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mod_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic       load;
    logic [7:0] load_val;
    logic       dir;

    logic [7:0] count1, count4;
    logic       tc1, tc4, wrap1, wrap4, ovf1, ovf4;

    int checks   = 0;
    int failures = 0;
    logic exp_ovf;

    mod_counter #(.WIDTH(8), .MOD(10), .PRESCALE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
        .load_val(load_val), .dir(dir),
        .count(count1), .tc(tc1), .wrap(wrap1), .ovf(ovf1)
    );

    mod_counter #(.WIDTH(8), .MOD(10), .PRESCALE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
        .load_val(load_val), .dir(dir),
        .count(count4), .tc(tc4), .wrap(wrap4), .ovf(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef COUNTER_OVF_STICKY_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0; load_val = 8'd0; dir = 1'b1;
        #3;
        chk("rst_count", 32'(count1), 0);
        chk("rst_wrap",  32'(wrap1), 0);
        chk("rst_ovf",   32'(ovf1), 0);
        chk("rst_tc_up", 32'(tc1), 0);
        dir = 1'b0;
        #1;
        chk("rst_tc_down", 32'(tc1), 1);

        edge_step();
        rst_n = 1'b1;
        dir   = 1'b1;
        en    = 1'b1;

        for (int i = 1; i <= 10; i++) begin
            edge_step();
            chk("up_count", 32'(count1), 32'(i % 10));
            chk("up_tc",    32'(tc1),    32'(i == 9));
            chk("up_wrap",  32'(wrap1),  32'(i == 10));
        end
        chk("up_ovf", 32'(ovf1), 32'(exp_ovf));

        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            edge_step();
            chk("hold_ovf",   32'(ovf1), 32'(exp_ovf));
            chk("hold_count", 32'(count1), 0);
        end
        chk("hold_wrap", 32'(wrap1), 0);

        dir = 1'b0;
        en  = 1'b1;
        edge_step();
        chk("down_wrap_count", 32'(count1), 9);
        chk("down_wrap_pulse", 32'(wrap1), 1);
        chk("down_tc_at9",     32'(tc1), 0);
        edge_step();
        chk("down_count", 32'(count1), 8);
        chk("down_wrap_clear", 32'(wrap1), 0);

        en = 1'b0; load = 1'b1; load_val = 8'd12;
        edge_step();
        chk("load_clamp", 32'(count1), 9);
        chk("load_wrap",  32'(wrap1), 0);
        load_val = 8'd5;
        edge_step();
        chk("load_en0", 32'(count1), 5);
        clr = 1'b1;
        edge_step();
        chk("clr_over_load_count", 32'(count1), 0);
        chk("clr_over_load_ovf",   32'(ovf1), 0);
        clr = 1'b0; en = 1'b1; dir = 1'b1; load_val = 8'd3;
        edge_step();
        chk("load_over_tick", 32'(count1), 3);
        load = 1'b0;

        // Fresh reset for the prescaled instance.
        #2 rst_n = 1'b0;
        #1;
        chk("prs_rst_count", 32'(count4), 0);
        en = 1'b0;
        edge_step();
        rst_n = 1'b1;
        en    = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            edge_step();
            chk("prs_count", 32'(count4), 32'(i / 4));
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            edge_step();
            chk("prs_hold", 32'(count4), 3);
        end
        en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            edge_step();
            chk("prs_resume", 32'(count4), (i == 4) ? 4 : 3);
        end

        // 10 more enabled edges: count 4 -> 6 with pre left at 2.
        for (int i = 0; i < 10; i++) begin
            edge_step();
        end
        chk("prs_pre_mid", 32'(count4), 6);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(count4), 0);
        chk("async_rst_wrap",  32'(wrap4), 0);
        chk("async_rst_ovf",   32'(ovf4), 0);
        edge_step();
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            edge_step();
            chk("post_rst_step", 32'(count4), (i == 4) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
